// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port synchronous SRAM between the instruction
// fetch port and the load/store port. Round-robin on conflict, one access at a
// time, each access walks IDLE -> ACCESS -> RESP. SRAM controls are registered.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no access in flight; arbitrate and launch on the next edge
//   ACCESS | sram_en (and sram_we for stores) high for this single cycle
//   RESP   | sram_rdata valid; owner's ack pulses, rdata passed through
module sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_ack,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  state_e              state_q,      state_d;
  owner_e              owner_q,      owner_d;
  owner_e              last_grant_q, last_grant_d;
  logic                store_q,      store_d;
  logic                sram_en_q,    sram_en_d;
  logic                sram_we_q,    sram_we_d;
  logic [ADDR_W-1:0]   sram_addr_q,  sram_addr_d;
  logic [DATA_W-1:0]   sram_wdata_q, sram_wdata_d;
  logic                grant_data;

  // State, ownership and registered SRAM controls; reset drops any access in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_INST;
      last_grant_q <= OWN_DATA;
      store_q      <= 1'b0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      store_q      <= store_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  // Arbitration and sequencing; requests are only looked at in IDLE.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    store_d      = store_q;
    sram_en_d    = sram_en_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    grant_data   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (inst_req || data_req) begin
          // On a tie the side that did not win last time gets the SRAM.
          grant_data   = data_req && (!inst_req || (last_grant_q == OWN_INST));
          owner_d      = grant_data ? OWN_DATA : OWN_INST;
          last_grant_d = grant_data ? OWN_DATA : OWN_INST;
          store_d      = grant_data && data_we;
          sram_en_d    = 1'b1;
          sram_we_d    = grant_data && data_we;
          sram_addr_d  = grant_data ? data_addr : inst_addr;
          sram_wdata_d = grant_data ? data_wdata : '0;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Address is left in place so the SRAM bus does not toggle needlessly.
        sram_en_d    = 1'b0;
        sram_we_d    = 1'b0;
        sram_wdata_d = '0;
        state_d      = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign inst_ack   = (state_q == S_RESP) && (owner_q == OWN_INST);
  assign data_ack   = (state_q == S_RESP) && (owner_q == OWN_DATA);
  assign inst_rdata = inst_ack ? sram_rdata : '0;
  // Stores return zero so the core never sees stale read data on a write ack.
  assign data_rdata = (data_ack && !store_q) ? sram_rdata : '0;

  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, per-port expectation queues drained
// by a monitor on the falling edge, plus directed timing checks.
module tb_sram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          inst_req = 1'b0;
  logic [AW-1:0] inst_addr = '0;
  logic          inst_ack;
  logic [DW-1:0] inst_rdata;
  logic          data_req = 1'b0;
  logic          data_we = 1'b0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic          data_ack;
  logic [DW-1:0] data_rdata;
  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic          busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_data_q[$];
  bit          ack_log[$];

  logic [31:0] mem [0:1023];

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .inst_req  (inst_req),
    .inst_addr (inst_addr),
    .inst_ack  (inst_ack),
    .inst_rdata(inst_rdata),
    .data_req  (data_req),
    .data_we   (data_we),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .data_ack  (data_ack),
    .data_rdata(data_rdata),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Single-port synchronous SRAM: read data appears the cycle after the en cycle.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr[11:2]] <= sram_wdata;
      else         sram_rdata <= mem[sram_addr[11:2]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every ack pops the expectation for its port.
  always @(negedge clk) begin
    if (resetn) begin
      if (inst_ack) begin
        if (exp_inst_q.size() == 0) begin
          n_total++;
          $display("FAIL inst_ack_unexpected: got ack=1 expected ack=0");
        end else begin
          check("inst_rdata", inst_rdata, exp_inst_q.pop_front());
        end
        ack_log.push_back(1'b0);
      end else begin
        check("inst_rdata_noack", inst_rdata, 32'h0);
      end
      if (data_ack) begin
        if (exp_data_q.size() == 0) begin
          n_total++;
          $display("FAIL data_ack_unexpected: got ack=1 expected ack=0");
        end else begin
          check("data_rdata", data_rdata, exp_data_q.pop_front());
        end
        ack_log.push_back(1'b1);
      end else begin
        check("data_rdata_noack", data_rdata, 32'h0);
      end
      check("ack_overlap", {31'b0, inst_ack & data_ack}, 32'h0);
    end
  end

  task automatic inst_txn(input logic [31:0] a, input logic [31:0] exp);
    bit got;
    got = 1'b0;
    inst_addr = a;
    inst_req  = 1'b1;
    exp_inst_q.push_back(exp);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_total++;
      $display("FAIL inst_timeout: got no ack in 20 cycles expected ack");
    end
    @(posedge clk); #1;
    inst_req = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp);
    bit got;
    got = 1'b0;
    data_we    = we;
    data_addr  = a;
    data_wdata = wd;
    data_req   = 1'b1;
    exp_data_q.push_back(exp);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_total++;
      $display("FAIL data_timeout: got no ack in 20 cycles expected ack");
    end
    @(posedge clk); #1;
    data_req = 1'b0;
    data_we  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_sram_en",    {31'b0, sram_en},  32'h0);
    check("rst_sram_we",    {31'b0, sram_we},  32'h0);
    check("rst_sram_addr",  sram_addr,         32'h0);
    check("rst_sram_wdata", sram_wdata,        32'h0);
    check("rst_busy",       {31'b0, busy},     32'h0);
    check("rst_inst_ack",   {31'b0, inst_ack}, 32'h0);
    check("rst_data_ack",   {31'b0, data_ack}, 32'h0);
    check("rst_inst_rdata", inst_rdata,        32'h0);
    check("rst_data_rdata", data_rdata,        32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Preload the fetch word through the store path
    data_txn(1'b1, 32'h1C00_0000, 32'h0280_0421, 32'h0);

    // Store with cycle-accurate SRAM strobe checks
    fork
      data_txn(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0);
      begin
        @(posedge clk); #1;
        check("st_c1_en",    {31'b0, sram_en}, 32'h1);
        check("st_c1_we",    {31'b0, sram_we}, 32'h1);
        check("st_c1_addr",  sram_addr,        32'h0000_0100);
        check("st_c1_wdata", sram_wdata,       32'hDEAD_BEEF);
        check("st_c1_busy",  {31'b0, busy},    32'h1);
        @(posedge clk); #1;
        check("st_c2_en",    {31'b0, sram_en},  32'h0);
        check("st_c2_we",    {31'b0, sram_we},  32'h0);
        check("st_c2_wdata", sram_wdata,        32'h0);
        check("st_c2_addr",  sram_addr,         32'h0000_0100);
        check("st_c2_ack",   {31'b0, data_ack}, 32'h1);
      end
    join

    // Single fetch
    fork
      inst_txn(32'h1C00_0000, 32'h0280_0421);
      begin
        @(posedge clk); #1;
        check("if_c1_en",   {31'b0, sram_en}, 32'h1);
        check("if_c1_we",   {31'b0, sram_we}, 32'h0);
        check("if_c1_addr", sram_addr,        32'h1C00_0000);
        @(posedge clk); #1;
        check("if_c2_iack", {31'b0, inst_ack}, 32'h1);
        check("if_c2_dack", {31'b0, data_ack}, 32'h0);
      end
    join

    // Load back the stored word
    data_txn(1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);

    // Simultaneous requests straight out of reset: INST first, then DATA
    resetn = 1'b0;
    #2;
    check("rst2_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    fork
      inst_txn(32'h1C00_0000, 32'h0280_0421);
      data_txn(1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
      begin
        @(posedge clk); #1;
        check("tie_c1_addr", sram_addr, 32'h1C00_0000);
        @(posedge clk); #1;
        check("tie_c2_iack", {31'b0, inst_ack}, 32'h1);
        check("tie_c2_dack", {31'b0, data_ack}, 32'h0);
        @(posedge clk); #1;
        check("tie_c3_busy", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;
        check("tie_c4_en",   {31'b0, sram_en}, 32'h1);
        check("tie_c4_addr", sram_addr,        32'h0000_0100);
        @(posedge clk); #1;
        check("tie_c5_dack", {31'b0, data_ack}, 32'h1);
        check("tie_c5_iack", {31'b0, inst_ack}, 32'h0);
      end
    join

    // Saturation: both sides re-request one cycle after each ack
    ack_log.delete();
    fork
      begin
        repeat (4) begin
          inst_txn(32'h1C00_0000, 32'h0280_0421);
          @(posedge clk); #1;
        end
      end
      begin
        repeat (4) begin
          data_txn(1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
          @(posedge clk); #1;
        end
      end
    join
    check("sat_ack_count", ack_log.size(), 32'd8);
    for (int i = 0; i < ack_log.size(); i++) begin
      check($sformatf("sat_order_%0d", i), {31'b0, ack_log[i]}, (i % 2 == 0) ? 32'h0 : 32'h1);
    end

    // Asynchronous reset in the middle of a store
    data_we    = 1'b1;
    data_addr  = 32'h0000_0200;
    data_wdata = 32'h1234_5678;
    data_req   = 1'b1;
    @(posedge clk); #1;
    check("mid_c1_en", {31'b0, sram_en}, 32'h1);
    check("mid_c1_we", {31'b0, sram_we}, 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_en",   {31'b0, sram_en}, 32'h0);
    check("mid_rst_we",   {31'b0, sram_we}, 32'h0);
    check("mid_rst_busy", {31'b0, busy},    32'h0);
    check("mid_rst_addr", sram_addr,        32'h0);
    data_req = 1'b0;
    data_we  = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("mid_rst_noack", {31'b0, data_ack}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    fork
      data_txn(1'b1, 32'h0000_0200, 32'h1234_5678, 32'h0);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reissue_lat", {31'b0, data_ack}, 32'h1);
      end
    join
    data_txn(1'b0, 32'h0000_0200, 32'h0, 32'h1234_5678);

    // Idle hold: nothing moves and the address is retained
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_en",   {31'b0, sram_en},  32'h0);
      check("idle_busy", {31'b0, busy},     32'h0);
      check("idle_iack", {31'b0, inst_ack}, 32'h0);
      check("idle_dack", {31'b0, data_ack}, 32'h0);
      check("idle_addr", sram_addr,         32'h0000_0200);
    end

    check("inst_queue_drained", exp_inst_q.size(), 32'd0);
    check("data_queue_drained", exp_data_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester arbiter that shares one single-port synchronous SRAM between the core's instruction-fetch port and its data (load/store) port. It sits between the multicycle core and a unified memory, replacing the separate inst/data SRAMs. Each requester uses a req/ack handshake. The arbiter grants one transaction at a time, round-robin on conflict, and sequences each access through a fixed three-state FSM.

## Interface
Parameters:
- ADDR_W, 32, address width of requesters and SRAM
- DATA_W, 32, data width

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request; held until inst_ack
- inst_addr  in  ADDR_W  fetch address; stable while inst_req=1
- inst_ack  out  1  one-cycle completion pulse
- inst_rdata  out  DATA_W  fetch data; valid only while inst_ack=1, else 0
- data_req  in  1  load/store request; held until data_ack
- data_we  in  1  1=store, 0=load; stable while data_req=1
- data_addr  in  ADDR_W  access address; stable while data_req=1
- data_wdata  in  DATA_W  store data; stable while data_req=1
- data_ack  out  1  one-cycle completion pulse
- data_rdata  out  DATA_W  load data; valid only while data_ack=1, else 0
- sram_en  out  1  SRAM access enable, registered
- sram_we  out  1  SRAM write enable, registered
- sram_addr  out  ADDR_W  SRAM address, registered
- sram_wdata  out  DATA_W  SRAM write data, registered
- sram_rdata  in  DATA_W  SRAM read data; valid the cycle after the en cycle
- busy  out  1  1 when the FSM is not in IDLE

## Operation
- The FSM has three states: IDLE, ACCESS and RESP. Owner register: INST or DATA. last_grant register: INST or DATA.
- IDLE: if no request is present, remain in IDLE. Otherwise, on the edge:
  - pick the owner;
  - load sram_addr, sram_wdata and sram_we from the owner's inputs (inst: we=0, wdata=0);
  - set sram_en=1;
  - go to ACCESS.
- Arbitration:
  - If only one request is present, it wins.
  - If both are present, the requester not equal to last_grant wins.
  - last_grant updates to the winner at the grant edge.
- ACCESS: sram_en/sram_we are high for exactly this one cycle. On the edge, clear sram_en, sram_we and sram_wdata, and go to RESP. sram_addr keeps its value.
- RESP:
  - The owner's ack is 1.
  - The owner's rdata = sram_rdata (combinational pass-through).
  - For stores, rdata = 0.
  - The non-owner's ack and rdata are 0.
  - On the edge, go to IDLE unconditionally.
- Requests sampled in RESP are ignored. A requester drops req in the cycle after ack; a req still high in IDLE is treated as a new transaction.
- The arbiter never reorders or merges accesses, and never issues two SRAM accesses for one request.
- A request that arrives while the other requester owns the SRAM waits (req held). It is granted in the next IDLE.
- Reset (async, any state):
  - state=IDLE, owner=INST, last_grant=DATA, so the first tie goes to INST.
  - sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
  - inst_ack=0, data_ack=0, both rdata=0, busy=0.
  - Any in-flight access is dropped with no ack; the requester re-issues it after reset.

## Timing
- Request seen in IDLE in cycle N:
  - sram_en=1 in N+1;
  - ack=1 and rdata valid in N+2;
  - IDLE again in N+3.
- Latency is 2 cycles from the sampled req to ack, for both reads and writes.
- A single requester holding req continuously is served every 3 cycles.
- With both requesters saturating, grants strictly alternate, each requester being served every 6 cycles. Worst-case wait is 3 cycles plus its own 2-cycle latency.
- busy=1 in ACCESS and RESP.
- sram_* outputs come directly from flops; ack/rdata are decoded from state/owner, with no input-to-output combinational path except sram_rdata→rdata.

## Test plan
- Single fetch: mem[0x1C000000]=0x02800421; inst_req=1 with inst_addr=0x1C000000 in cycle 0 → sram_en=1, we=0, addr=0x1C000000 in cycle 1; inst_ack=1 with inst_rdata=0x02800421 in cycle 2; data_ack stays 0.
- Store then load:
  - data_we=1, addr=0x100, wdata=0xDEADBEEF → sram_we=1 in cycle 1; data_ack in cycle 2 with data_rdata=0.
  - Then a load from 0x100 → data_rdata=0xDEADBEEF on its ack.
- Simultaneous requests out of reset: both req=1 in cycle 0 → INST acked in cycle 2; DATA granted in cycle 3 and acked in cycle 5; last_grant=DATA.
- Saturation: both req held for 24 cycles, each dropped for one cycle after its ack → acks alternate INST, DATA, INST, … (8 total, 4 each). No two accesses overlap; inst_ack and data_ack are never high in the same cycle.
- Reset mid-access: assert resetn=0 asynchronously while in ACCESS for a data store → sram_en=0, sram_we=0 and busy=0 immediately, without waiting for a clock edge; no data_ack follows. After release, a re-issued request completes in 2 cycles.
- Idle hold: no requests for 10 cycles → sram_en=0, busy=0, both acks 0, and sram_addr keeps its last value.
